ws2812_bit_encoder: RTL and testbench
=====================================

Name: ws2812_bit_encoder

Overview:
- Downstream consumer of the single-bit LED data FIFO. Pops one bit at a time from the FIFO read side and encodes it into the WS2812-style one-wire NRZ pulse waveform on o_led_data.
- Closes each frame with the low latch/reset period the LED strip requires.
- Sits between the bit FIFO and the output pad driving the strip.

Parameters:
- T0H_CYCLES, 20, high time of a '0' bit in clock cycles (0.4 us at 50 MHz)
- T1H_CYCLES, 40, high time of a '1' bit in clock cycles (0.8 us at 50 MHz)
- BIT_CYCLES, 63, total bit period in clock cycles (1.26 us at 50 MHz)
- RESET_CYCLES, 2500, low latch period closing a frame (50 us at 50 MHz)
- Elaboration checks, fatal on violation: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES; RESET_CYCLES >= 1.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_enable  input  1  allow new bits to be popped
- i_fifo_data  input  1  FIFO head bit; valid whenever i_fifo_empty=0 (first-word-fall-through)
- i_fifo_empty  input  1  FIFO empty flag
- o_fifo_read  output  1  pop strobe, one cycle per consumed bit
- o_led_data  output  1  encoded serial line to the strip (registered)
- o_busy  output  1  high in HIGH, LOW and LATCH states
- o_frame_done  output  1  single-cycle pulse on the last LATCH cycle

Behaviour:
- Reset values: o_led_data=0, o_fifo_read=0, o_busy=0, o_frame_done=0, state=IDLE, counters=0. Reset is sampled on i_clk only.
- Reset mid-operation aborts immediately:
  - o_led_data is 0 from the next edge.
  - No pop occurs while i_reset=1.
  - A truncated pulse on the line is acceptable.
- States: IDLE, HIGH, LOW, LATCH. A single cycle counter cnt has width $clog2(max(BIT_CYCLES,RESET_CYCLES)+1).
- Pop condition: pop = i_enable & ~i_fifo_empty, evaluated only in IDLE, or on the last LOW cycle.
  - o_fifo_read is combinational and equal to pop in those cycles; it is 0 otherwise.
  - The bit is captured from i_fifo_data in the same cycle.
- IDLE:
  - On pop, capture the bit, set cnt=0 and go to HIGH.
  - Otherwise stay in IDLE with o_led_data=0.
- HIGH:
  - o_led_data=1.
  - Stay for TxH cycles (T1H_CYCLES if the bit is 1, else T0H_CYCLES), then go to LOW.
- LOW:
  - o_led_data=0 until cnt reaches BIT_CYCLES-1 counted from the first HIGH cycle.
  - On the last LOW cycle with pop: capture the next bit and go to HIGH. There is no gap, so the bit period is exactly BIT_CYCLES.
  - On the last LOW cycle without pop (FIFO empty or i_enable=0): go to LATCH with cnt=0.
- LATCH:
  - o_led_data=0 for exactly RESET_CYCLES cycles.
  - o_frame_done=1 on the final cycle, then go to IDLE.
  - The FIFO is not popped in LATCH, even if data arrives. The earliest next pop is the first IDLE cycle.
- Latency: o_led_data rises on the cycle after the pop cycle.
- Bits are emitted in FIFO order. Byte and colour ordering is the upstream's responsibility.
- Underrun mid-frame is treated as end of frame: the full LATCH runs and no error flag is raised.
- i_enable deasserted mid-bit: the current bit completes with full BIT_CYCLES, then LATCH, then IDLE.
- Simultaneous last-LOW-cycle and FIFO becoming non-empty in that same cycle: the pop occurs, because the decision uses current-cycle i_fifo_empty.

Decomposition:
- Shared package leaflab_pkg holds:
  - The state typedef enum {IDLE, HIGH, LOW, LATCH}.
  - Default timing constants for 50 MHz (T0H, T1H, BIT, RESET cycles) used as parameter defaults.
- No sub-module. A single module of about 150 lines with one counter and the FSM.

Test Plan:
- Single '1' with defaults: FIFO holds 1 bit; pop at cycle N -> o_led_data high N+1..N+40, low N+41..N+63, then 2500 low LATCH cycles; o_frame_done pulses once; o_busy falls the cycle after.
- Back-to-back 24 bits 0xA53CFF pre-filled: 24 o_fifo_read pulses exactly 63 cycles apart; high widths 40/20 match bit values in FIFO order; one LATCH; one o_frame_done.
- Underrun: 8 bits, then 100 cycles after the last pop push 1 more bit -> full 2500-cycle LATCH after bit 8; new bit popped on the first IDLE cycle after o_frame_done; no pop inside LATCH.
- Enable drop: deassert i_enable during HIGH of bit 3 of 8 -> bit 3 completes its 63-cycle period, LATCH follows, 5 bits remain in the FIFO, no further o_fifo_read.
- Reset mid-HIGH: assert i_reset for 2 cycles during a '1' high phase -> o_led_data=0 from the next edge, o_fifo_read=0 and o_busy=0 throughout reset, restart from IDLE afterwards.
- Idle/empty: i_enable=1 with FIFO empty for 1000 cycles -> o_fifo_read, o_led_data and o_busy all remain 0.

Source files
------------

// File: rtl/leaflab_pkg.sv
// Shared types and 50 MHz timing defaults for the LED strip datapath.
package leaflab_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } enc_state_t;

    localparam int unsigned DEF_T0H_CYCLES   = 20;
    localparam int unsigned DEF_T1H_CYCLES   = 40;
    localparam int unsigned DEF_BIT_CYCLES   = 63;
    localparam int unsigned DEF_RESET_CYCLES = 2500;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder_if.sv
// Read side of the first-word-fall-through bit FIFO, named from the encoder's view.
interface ws2812_bit_encoder_if;
    logic i_fifo_data;
    logic i_fifo_empty;
    logic o_fifo_read;

    modport master (
        input  i_fifo_data,
        input  i_fifo_empty,
        output o_fifo_read
    );

    modport slave (
        output i_fifo_data,
        output i_fifo_empty,
        input  o_fifo_read
    );
endinterface

// File: rtl/ws2812_bit_encoder.sv
// Pops bits from the FIFO and emits WS2812 NRZ pulses, closing each frame with a low latch period.
module ws2812_bit_encoder
    import leaflab_pkg::*;
#(
    parameter int unsigned T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int unsigned T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int unsigned BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    ws2812_bit_encoder_if.master fifo,
    output logic                 o_led_data,
    output logic                 o_busy,
    output logic                 o_frame_done
);

    localparam int unsigned CNT_W = $clog2(max_u(BIT_CYCLES, RESET_CYCLES) + 1);

    localparam logic [CNT_W-1:0] T0H_LAST   = CNT_W'(T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1H_LAST   = CNT_W'(T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);

    if (!((T0H_CYCLES > 0) && (T0H_CYCLES < T1H_CYCLES) &&
          (T1H_CYCLES < BIT_CYCLES) && (RESET_CYCLES >= 1))) begin : g_bad_params
        $fatal(1, "ws2812_bit_encoder: illegal timing parameters");
    end

    enc_state_t       r_state;
    enc_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_bit;
    logic             w_bit_nxt;
    logic             r_led_data;
    logic             w_pop_ok;
    logic             w_pop;
    logic             w_frame_done;
    logic             w_high_last;

    assign w_pop_ok    = i_enable & ~fifo.i_fifo_empty & ~i_reset;
    assign w_high_last = r_bit ? (r_cnt == T1H_LAST) : (r_cnt == T0H_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= 1'b0;
            r_led_data <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            // Registered line follows the state being entered, so it rises the cycle after a pop.
            r_led_data <= (w_state_nxt == HIGH);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_bit_nxt    = r_bit;
        w_pop        = 1'b0;
        w_frame_done = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_pop_ok) begin
                    w_pop       = 1'b1;
                    w_bit_nxt   = fifo.i_fifo_data;
                    w_state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (w_high_last) begin
                    w_state_nxt = LOW;
                end
            end
            LOW: begin
                // cnt keeps running from the first HIGH cycle, so the bit period is BIT_CYCLES.
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_pop_ok) begin
                        w_pop       = 1'b1;
                        w_bit_nxt   = fifo.i_fifo_data;
                        w_state_nxt = HIGH;
                    end else begin
                        w_state_nxt = LATCH;
                    end
                end
            end
            LATCH: begin
                if (r_cnt == RESET_LAST) begin
                    w_frame_done = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign fifo.o_fifo_read = w_pop;
    assign o_led_data       = r_led_data;
    assign o_busy           = (r_state != IDLE);
    assign o_frame_done     = w_frame_done;

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Directed bench for ws2812_bit_encoder with a queue-backed FWFT FIFO and per-cycle event logs.
module tb_ws2812_bit_encoder;

    logic clk = 1'b0;
    logic i_reset;
    logic i_enable;
    logic o_led_data;
    logic o_busy;
    logic o_frame_done;

    ws2812_bit_encoder_if fif ();

    ws2812_bit_encoder #(
        .T0H_CYCLES  (20),
        .T1H_CYCLES  (40),
        .BIT_CYCLES  (63),
        .RESET_CYCLES(2500)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .fifo        (fif.master),
        .o_led_data  (o_led_data),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    int   passed = 0;
    int   total  = 0;
    int   cycle  = 0;
    bit   q[$];
    int   pop_log[$];
    int   rise_log[$];
    int   hw_log[$];
    int   done_log[$];
    int   bfall_log[$];
    logic obs_rd, obs_led, obs_busy, obs_done;
    logic prev_led  = 1'b0;
    logic prev_busy = 1'b0;
    int   rise_start = 0;

    task automatic update_fifo();
        fif.i_fifo_empty = (q.size() == 0);
        fif.i_fifo_data  = (q.size() > 0) ? q[0] : 1'b0;
    endtask

    task automatic push_bit(input bit b);
        q.push_back(b);
        update_fifo();
    endtask

    task automatic clear_logs();
        pop_log.delete();
        rise_log.delete();
        hw_log.delete();
        done_log.delete();
        bfall_log.delete();
    endtask

    // Observe the current interval at the falling edge, then advance one rising edge.
    task automatic cyc();
        @(negedge clk);
        obs_rd   = fif.o_fifo_read;
        obs_led  = o_led_data;
        obs_busy = o_busy;
        obs_done = o_frame_done;
        if (obs_rd) pop_log.push_back(cycle);
        if (obs_led && !prev_led) begin
            rise_start = cycle;
            rise_log.push_back(cycle);
        end
        if (!obs_led && prev_led) hw_log.push_back(cycle - rise_start);
        if (obs_done) done_log.push_back(cycle);
        if (!obs_busy && prev_busy) bfall_log.push_back(cycle);
        prev_led  = obs_led;
        prev_busy = obs_busy;
        @(posedge clk);
        #1;
        cycle++;
        if (obs_rd && q.size() > 0) void'(q.pop_front());
        update_fifo();
    endtask

    task automatic test_reset();
        int bad_rd = 0, bad_led = 0, bad_busy = 0, bad_done = 0;
        i_reset  = 1'b1;
        i_enable = 1'b1;
        push_bit(1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (obs_rd !== 1'b0)   bad_rd++;
            if (obs_led !== 1'b0)  bad_led++;
            if (obs_busy !== 1'b0) bad_busy++;
            if (obs_done !== 1'b0) bad_done++;
        end
        total++; if (bad_rd != 0)   $display("FAIL reset_read: %0d cycles high, want 0", bad_rd);   else passed++;
        total++; if (bad_led != 0)  $display("FAIL reset_led: %0d cycles high, want 0", bad_led);   else passed++;
        total++; if (bad_busy != 0) $display("FAIL reset_busy: %0d cycles high, want 0", bad_busy); else passed++;
        total++; if (bad_done != 0) $display("FAIL reset_done: %0d cycles high, want 0", bad_done); else passed++;
        q.delete();
        update_fifo();
        i_reset = 1'b0;
        cyc();
    endtask

    task automatic test_single_one();
        int n;
        clear_logs();
        push_bit(1'b1);
        for (int i = 0; i < 3000 && done_log.size() < 1; i++) cyc();
        for (int i = 0; i < 5; i++) cyc();
        n = (pop_log.size() > 0) ? pop_log[0] : 0;
        total++; if (pop_log.size() !== 1) $display("FAIL single_pops: got %0d want 1", pop_log.size()); else passed++;
        total++; if (rise_log.size() !== 1 || rise_log[0] !== n + 1)
            $display("FAIL single_rise: got %0d rises first at %0d want 1 at %0d", rise_log.size(), (rise_log.size() > 0) ? rise_log[0] : -1, n + 1);
        else passed++;
        total++; if (hw_log.size() < 1 || hw_log[0] !== 40)
            $display("FAIL single_high_width: got %0d want 40", (hw_log.size() > 0) ? hw_log[0] : -1);
        else passed++;
        total++; if (done_log.size() !== 1 || done_log[0] !== n + 2563)
            $display("FAIL single_frame_done: got %0d pulses first at %0d want 1 at %0d", done_log.size(), (done_log.size() > 0) ? done_log[0] : -1, n + 2563);
        else passed++;
        total++; if (bfall_log.size() !== 1 || bfall_log[0] !== n + 2564)
            $display("FAIL single_busy_fall: got %0d at %0d want 1 at %0d", bfall_log.size(), (bfall_log.size() > 0) ? bfall_log[0] : -1, n + 2564);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [23:0] pat;
        int bad_gap = 0, bad_w = 0, last;
        pat = 24'hA53CFF;
        clear_logs();
        i_enable = 1'b0;
        for (int i = 0; i < 24; i++) push_bit(pat[23 - i]);
        cyc();
        i_enable = 1'b1;
        for (int i = 0; i < 4200 && done_log.size() < 1; i++) cyc();
        cyc();
        total++; if (pop_log.size() !== 24) $display("FAIL b2b_pops: got %0d want 24", pop_log.size()); else passed++;
        for (int i = 1; i < pop_log.size(); i++)
            if (pop_log[i] - pop_log[i - 1] != 63) bad_gap++;
        total++; if (bad_gap != 0) $display("FAIL b2b_gap: %0d gaps differ from 63", bad_gap); else passed++;
        for (int i = 0; i < 24; i++)
            if (i >= hw_log.size() || hw_log[i] != (pat[23 - i] ? 40 : 20)) bad_w++;
        total++; if (bad_w != 0) $display("FAIL b2b_widths: %0d widths wrong of 24", bad_w); else passed++;
        last = (pop_log.size() > 0) ? pop_log[pop_log.size() - 1] : 0;
        total++; if (done_log.size() !== 1 || done_log[0] !== last + 2563)
            $display("FAIL b2b_frame_done: got %0d pulses first at %0d want 1 at %0d", done_log.size(), (done_log.size() > 0) ? done_log[0] : -1, last + 2563);
        else passed++;
    endtask

    task automatic test_underrun();
        logic [7:0] pat;
        int p;
        pat = 8'h5A;
        clear_logs();
        for (int i = 0; i < 8; i++) push_bit(pat[7 - i]);
        for (int i = 0; i < 600 && pop_log.size() < 8; i++) cyc();
        p = (pop_log.size() > 7) ? pop_log[7] : 0;
        while (cycle < p + 100) cyc();
        push_bit(1'b0);
        for (int i = 0; i < 3000 && pop_log.size() < 9; i++) cyc();
        total++; if (pop_log.size() !== 9) $display("FAIL underrun_pops: got %0d want 9", pop_log.size()); else passed++;
        total++; if (done_log.size() < 1 || done_log[0] !== p + 2563)
            $display("FAIL underrun_latch_end: got %0d want %0d", (done_log.size() > 0) ? done_log[0] : -1, p + 2563);
        else passed++;
        total++; if (pop_log.size() < 9 || pop_log[8] !== p + 2564)
            $display("FAIL underrun_repop: got %0d want %0d", (pop_log.size() > 8) ? pop_log[8] : -1, p + 2564);
        else passed++;
        total++; if (hw_log.size() < 2 || hw_log[0] !== 20 || hw_log[1] !== 40)
            $display("FAIL underrun_widths: got %0d,%0d want 20,40", (hw_log.size() > 0) ? hw_log[0] : -1, (hw_log.size() > 1) ? hw_log[1] : -1);
        else passed++;
        for (int i = 0; i < 3000 && done_log.size() < 2; i++) cyc();
        total++; if (done_log.size() !== 2 || pop_log.size() < 9 || done_log[1] !== pop_log[8] + 2563)
            $display("FAIL underrun_second_frame: got %0d pulses want 2", done_log.size());
        else passed++;
    endtask

    task automatic test_enable_drop();
        logic [7:0] pat;
        int qb;
        pat = 8'hC3;
        clear_logs();
        for (int i = 0; i < 8; i++) push_bit(pat[7 - i]);
        for (int i = 0; i < 300 && pop_log.size() < 3; i++) cyc();
        qb = (pop_log.size() > 2) ? pop_log[2] : 0;
        while (cycle < qb + 5) cyc();
        i_enable = 1'b0;
        for (int i = 0; i < 3000 && done_log.size() < 1; i++) cyc();
        total++; if (done_log.size() !== 1 || done_log[0] !== qb + 2563)
            $display("FAIL endrop_latch_end: got %0d want %0d", (done_log.size() > 0) ? done_log[0] : -1, qb + 2563);
        else passed++;
        total++; if (hw_log.size() < 3 || hw_log[2] !== 20)
            $display("FAIL endrop_bit3_width: got %0d want 20", (hw_log.size() > 2) ? hw_log[2] : -1);
        else passed++;
        for (int i = 0; i < 200; i++) cyc();
        total++; if (pop_log.size() !== 3) $display("FAIL endrop_pops: got %0d want 3", pop_log.size()); else passed++;
        total++; if (q.size() !== 5) $display("FAIL endrop_remaining: got %0d want 5", q.size()); else passed++;
        q.delete();
        update_fifo();
        i_enable = 1'b1;
    endtask

    task automatic test_reset_mid_high();
        int r;
        clear_logs();
        push_bit(1'b1);
        for (int i = 0; i < 10 && pop_log.size() < 1; i++) cyc();
        r = (pop_log.size() > 0) ? pop_log[0] : 0;
        push_bit(1'b1);
        push_bit(1'b0);
        while (cycle < r + 11) cyc();
        i_reset = 1'b1;
        cyc();
        total++; if (obs_rd !== 1'b0) $display("FAIL rstmid_read_a: got %b want 0", obs_rd); else passed++;
        cyc();
        total++; if (obs_rd !== 1'b0)   $display("FAIL rstmid_read_b: got %b want 0", obs_rd);   else passed++;
        total++; if (obs_led !== 1'b0)  $display("FAIL rstmid_led: got %b want 0", obs_led);     else passed++;
        total++; if (obs_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", obs_busy);   else passed++;
        i_reset = 1'b0;
        cyc();
        total++; if (obs_led !== 1'b0 || obs_busy !== 1'b0)
            $display("FAIL rstmid_idle: led %b busy %b want 0 0", obs_led, obs_busy);
        else passed++;
        total++; if (obs_rd !== 1'b1) $display("FAIL rstmid_restart_pop: got %b want 1", obs_rd); else passed++;
        cyc();
        total++; if (obs_led !== 1'b1) $display("FAIL rstmid_restart_led: got %b want 1", obs_led); else passed++;
        for (int i = 0; i < 3000 && done_log.size() < 1; i++) cyc();
        total++; if (pop_log.size() !== 3 || q.size() !== 0)
            $display("FAIL rstmid_drain: got %0d pops %0d left want 3 0", pop_log.size(), q.size());
        else passed++;
    endtask

    task automatic test_idle_empty();
        int n_rd = 0, n_led = 0, n_busy = 0;
        clear_logs();
        i_enable = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            if (obs_rd !== 1'b0)   n_rd++;
            if (obs_led !== 1'b0)  n_led++;
            if (obs_busy !== 1'b0) n_busy++;
        end
        total++; if (n_rd != 0)   $display("FAIL idle_read: %0d cycles high want 0", n_rd);   else passed++;
        total++; if (n_led != 0)  $display("FAIL idle_led: %0d cycles high want 0", n_led);   else passed++;
        total++; if (n_busy != 0) $display("FAIL idle_busy: %0d cycles high want 0", n_busy); else passed++;
    endtask

    initial begin
        i_reset  = 1'b1;
        i_enable = 1'b0;
        update_fifo();
        test_reset();
        test_single_one();
        test_back_to_back();
        test_underrun();
        test_enable_drop();
        test_reset_mid_high();
        test_idle_empty();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
